interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Collects external interrupt lines and synchronises and edge-detects them.
- Prioritises unmasked pending lines and sequences one interrupt at a time into the CPU.
- Handshake with the CPU: request, acknowledge at an instruction boundary, return via RETI.
- Supplies the interrupt ID that the CPU writes to dreg on OP_INTID (getIntID). No nesting: one interrupt is in service at a time.

Parameters:
- NUM_INT, 8, number of interrupt lines (1..15).
- ID_WIDTH, 4, width of int_id; must satisfy 2^ID_WIDTH > NUM_INT.
- SYNC_STAGES, 2, synchroniser flops per input line (>= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- int_in  input  NUM_INT  raw asynchronous interrupt lines; a rising edge requests an interrupt.
- mask_we  input  1  write strobe for the mask register.
- mask_wdata  input  NUM_INT  new mask value; a 1 disables the corresponding line.
- int_ack  input  1  one-cycle pulse from the CPU: request taken at an instruction boundary.
- reti  input  1  one-cycle pulse from the CPU when it executes OP_RETI.
- int_req  output  1  interrupt request to the CPU.
- int_id  output  ID_WIDTH  ID of the requested or in-service line (index+1); 0 when idle.
- in_service  output  1  high while an interrupt handler is running.
- pending  output  NUM_INT  pending register, for debug/readback.
- mask  output  NUM_INT  current mask register.

Behaviour:
- Reset (reset_n low, asynchronous), all of the following cleared:
  - outputs int_req=0, int_id=0, in_service=0, pending=0, mask=0 (all lines enabled);
  - all synchroniser flops and edge-detect history flops;
  - state=IDLE.
  - Reset asserted mid-handshake abandons the interrupt; no pending bit survives.
- Input path, per line:
  - SYNC_STAGES flop chain, then a history flop.
  - Rise = last sync stage is 1 and history is 0.
  - A rise sets pending[i] at the next edge. Levels and falling edges are ignored.
- Latency (SYNC_STAGES=2):
  - int_in high first sampled at edge E0;
  - pending set at E2;
  - state REQ with int_req=1 after E3 (when IDLE and unmasked).
- Mask:
  - mask_we loads mask_wdata at the edge.
  - Masking does not clear pending bits. A masked pending line is requested once it is unmasked.
- Priority: lowest index wins (line 0 highest). Selection is over pending & ~mask.
- State machine:
  - IDLE:
    - If any unmasked pending bit: latch sel_id = index+1 into int_id, go REQ.
    - Else int_id=0.
  - REQ:
    - int_req=1, int_id holds the latched value.
    - Mask writes and new higher-priority edges do not change the latched id; the request stays committed until acked.
    - On int_ack: clear pending[latched line], int_req=0, in_service=1, go SERVICE.
  - SERVICE:
    - in_service=1, int_id held (the value read by OP_INTID).
    - No new request is issued.
    - On reti: in_service=0, int_id=0, go IDLE.
    - The next request can assert one cycle after IDLE is entered, so there is at least one idle cycle between interrupts.
- Simultaneous events:
  - Rise on the latched line in the same cycle as int_ack: the set wins, pending stays 1, and the line is requested again after reti.
  - mask_we in the same cycle as the IDLE->REQ decision: selection uses the old mask.
  - int_ack outside REQ is ignored; reti outside SERVICE is ignored.
  - int_ack and reti in the same cycle: only the one valid for the current state acts.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then single edge on int_in[3] (low->high at edge E0) -> pending=0x08 at E2, int_req=1 and int_id=4 after E3; int_ack -> int_req=0, in_service=1, pending=0; reti -> in_service=0, int_id=0.
- Edges on int_in[5] and int_in[1] in the same cycle -> int_id=2 first; after ack+reti, int_id=6 requested one idle cycle later; pending=0 at end.
- mask=0x04, edge on int_in[2] -> pending=0x04, int_req stays 0 for 20 cycles; write mask=0x00 -> int_req=1, int_id=3 on the following cycle.
- In SERVICE with int_id=1: edge on int_in[0] -> pending[0]=1, no int_req; reti -> IDLE, then int_req=1, int_id=1.
- Edge on the latched line coincident with int_ack -> pending bit remains 1; stray int_ack in IDLE and stray reti in REQ -> no state change.
- Assert reset_n=0 while in REQ and while in SERVICE -> all outputs 0 immediately, without waiting for a clock edge; int_in held high through reset release -> no request (no new rise).

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Collects external interrupt lines, synchronises and rising-edge detects
//   them, prioritises unmasked pending lines (line 0 highest) and hands one
//   interrupt at a time to the CPU through a req/ack/reti handshake.
//   No nesting: while a handler runs, no new request is issued.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   int_in      raw asynchronous interrupt lines (rising edge requests)
//   mask_we     mask register write strobe
//   mask_wdata  new mask value (1 = line disabled)
//   int_ack     CPU took the request at an instruction boundary (pulse)
//   reti        CPU executed RETI (pulse)
//   int_req     interrupt request to the CPU (registered)
//   int_id      requested / in-service line index+1, 0 when idle (registered)
//   in_service  handler running (registered)
//   pending     pending register (readback)
//   mask        mask register (readback)
module interrupt_controller #(
    parameter int NUM_INT     = 8,
    parameter int ID_WIDTH    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_INT-1:0]  int_in,
    input  logic                mask_we,
    input  logic [NUM_INT-1:0]  mask_wdata,
    input  logic                int_ack,
    input  logic                reti,
    output logic                int_req,
    output logic [ID_WIDTH-1:0] int_id,
    output logic                in_service,
    output logic [NUM_INT-1:0]  pending,
    output logic [NUM_INT-1:0]  mask
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    logic [NUM_INT-1:0]  sync_r [SYNC_STAGES];
    logic [NUM_INT-1:0]  hist_r;
    // Warm-up shift register: edge detection is enabled only once the
    // synchroniser and history flops hold real samples, so a line that is
    // already high when reset is released is seen as a level, not an edge.
    logic [SYNC_STAGES:0] warm_r;

    logic [NUM_INT-1:0]  rise_s;
    logic [NUM_INT-1:0]  avail_s;
    logic [NUM_INT-1:0]  latched_s;
    logic [NUM_INT-1:0]  pend_clr_s;
    logic [NUM_INT-1:0]  pending_r;
    logic [NUM_INT-1:0]  pending_nxt_s;
    logic [NUM_INT-1:0]  mask_r;
    logic [ID_WIDTH-1:0] sel_id_s;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                int_req_r;
    logic                int_req_nxt_s;
    logic [ID_WIDTH-1:0] int_id_r;
    logic [ID_WIDTH-1:0] int_id_nxt_s;
    logic                in_service_r;
    logic                in_service_nxt_s;

    // Input synchroniser chain, edge-detect history and warm-up tracker.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= '0;
            end
            hist_r <= '0;
            warm_r <= '0;
        end else begin
            sync_r[0] <= int_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
            hist_r <= sync_r[SYNC_STAGES-1];
            warm_r <= {warm_r[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Rising-edge detection on the synchronised lines.
    always_comb begin
        if (warm_r[SYNC_STAGES]) begin
            rise_s = sync_r[SYNC_STAGES-1] & ~hist_r;
        end else begin
            rise_s = '0;
        end
    end

    // Fixed-priority selection over unmasked pending lines, lowest index wins.
    always_comb begin
        avail_s  = pending_r & ~mask_r;
        sel_id_s = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            sel_id_s = avail_s[i] ? ID_WIDTH'(i + 1) : sel_id_s;
        end
    end

    // One-hot of the line whose id is currently latched.
    always_comb begin
        latched_s = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            latched_s[i] = (int_id_r == ID_WIDTH'(i + 1));
        end
    end

    // Handshake FSM next-state and next-output logic.
    always_comb begin
        state_nxt_s      = state_r;
        int_req_nxt_s    = int_req_r;
        int_id_nxt_s     = int_id_r;
        in_service_nxt_s = in_service_r;
        pend_clr_s       = '0;
        case (state_r)
            ST_IDLE: begin
                in_service_nxt_s = 1'b0;
                if (|avail_s) begin
                    state_nxt_s   = ST_REQ;
                    int_req_nxt_s = 1'b1;
                    int_id_nxt_s  = sel_id_s;
                end else begin
                    int_req_nxt_s = 1'b0;
                    int_id_nxt_s  = '0;
                end
            end
            ST_REQ: begin
                // Request is committed: the latched id is held until acked.
                if (int_ack) begin
                    state_nxt_s      = ST_SERVICE;
                    int_req_nxt_s    = 1'b0;
                    in_service_nxt_s = 1'b1;
                    pend_clr_s       = latched_s;
                end else begin
                    int_req_nxt_s = 1'b1;
                end
            end
            ST_SERVICE: begin
                int_req_nxt_s = 1'b0;
                if (reti) begin
                    state_nxt_s      = ST_IDLE;
                    in_service_nxt_s = 1'b0;
                    int_id_nxt_s     = '0;
                end else begin
                    in_service_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s      = ST_IDLE;
                int_req_nxt_s    = 1'b0;
                int_id_nxt_s     = '0;
                in_service_nxt_s = 1'b0;
            end
        endcase
        // A new rise wins over the acknowledge clear in the same cycle.
        pending_nxt_s = (pending_r & ~pend_clr_s) | rise_s;
    end

    // FSM state, registered outputs and pending register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            int_req_r    <= 1'b0;
            int_id_r     <= '0;
            in_service_r <= 1'b0;
            pending_r    <= '0;
        end else begin
            state_r      <= state_nxt_s;
            int_req_r    <= int_req_nxt_s;
            int_id_r     <= int_id_nxt_s;
            in_service_r <= in_service_nxt_s;
            pending_r    <= pending_nxt_s;
        end
    end

    // Mask register; selection in the same cycle sees the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r <= '0;
        end else if (mask_we) begin
            mask_r <= mask_wdata;
        end else begin
            mask_r <= mask_r;
        end
    end

    assign int_req    = int_req_r;
    assign int_id     = int_id_r;
    assign in_service = in_service_r;
    assign pending    = pending_r;
    assign mask       = mask_r;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] int_in = 8'h00;
    logic       mask_we = 1'b0;
    logic [7:0] mask_wdata = 8'h00;
    logic       int_ack = 1'b0;
    logic       reti = 1'b0;
    logic       int_req;
    logic [3:0] int_id;
    logic       in_service;
    logic [7:0] pending;
    logic [7:0] mask;

    int vectors = 0;
    int miscompares = 0;

    interrupt_controller #(
        .NUM_INT(8),
        .ID_WIDTH(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .int_in(int_in),
        .mask_we(mask_we),
        .mask_wdata(mask_wdata),
        .int_ack(int_ack),
        .reti(reti),
        .int_req(int_req),
        .int_id(int_id),
        .in_service(in_service),
        .pending(pending),
        .mask(mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic req_e, input logic [3:0] id_e,
                             input logic svc_e, input logic [7:0] pend_e);
        check({tag, ".int_req"}, 32'(int_req), 32'(req_e));
        check({tag, ".int_id"}, 32'(int_id), 32'(id_e));
        check({tag, ".in_service"}, 32'(in_service), 32'(svc_e));
        check({tag, ".pending"}, 32'(pending), 32'(pend_e));
    endtask

    task automatic write_mask(input logic [7:0] v);
        mask_we = 1'b1;
        mask_wdata = v;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic do_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    initial begin
        // Reset state
        ticks(3);
        check_out("reset", 1'b0, 4'd0, 1'b0, 8'h00);
        check("reset.mask", 32'(mask), 32'h0);
        reset_n = 1'b1;
        ticks(5);

        // Single edge on line 3: pending at E2, request after E3
        int_in = 8'h08;
        ticks(2);
        check("t1.pend_E1", 32'(pending), 32'h00);
        tick();
        check_out("t1.E2", 1'b0, 4'd0, 1'b0, 8'h08);
        tick();
        check_out("t1.E3", 1'b1, 4'd4, 1'b0, 8'h08);
        do_ack();
        check_out("t1.ack", 1'b0, 4'd4, 1'b1, 8'h00);
        int_in = 8'h00;
        ticks(3);
        check_out("t1.svc", 1'b0, 4'd4, 1'b1, 8'h00);
        do_reti();
        check_out("t1.reti", 1'b0, 4'd0, 1'b0, 8'h00);
        ticks(3);

        // Simultaneous edges on lines 5 and 1: line 1 first
        int_in = 8'h22;
        ticks(3);
        check("t2.pend", 32'(pending), 32'h22);
        tick();
        check_out("t2.req1", 1'b1, 4'd2, 1'b0, 8'h22);
        do_ack();
        check_out("t2.ack1", 1'b0, 4'd2, 1'b1, 8'h20);
        do_reti();
        check_out("t2.idle_gap", 1'b0, 4'd0, 1'b0, 8'h20);
        tick();
        check_out("t2.req5", 1'b1, 4'd6, 1'b0, 8'h20);
        do_ack();
        do_reti();
        check_out("t2.end", 1'b0, 4'd0, 1'b0, 8'h00);
        int_in = 8'h00;
        ticks(3);

        // Masked line stays pending, requested after unmask
        write_mask(8'h04);
        check("t3.mask", 32'(mask), 32'h04);
        int_in = 8'h04;
        ticks(3);
        check("t3.pend", 32'(pending), 32'h04);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("t3.masked_req", 32'(int_req), 32'h0);
        end
        write_mask(8'h00);
        check("t3.unmask_edge_req", 32'(int_req), 32'h0);
        tick();
        check_out("t3.req", 1'b1, 4'd3, 1'b0, 8'h04);
        do_ack();
        do_reti();
        int_in = 8'h00;
        ticks(3);

        // Edge on line 0 while servicing line 0: held until reti
        int_in = 8'h01;
        ticks(4);
        check_out("t4.req", 1'b1, 4'd1, 1'b0, 8'h01);
        do_ack();
        check_out("t4.ack", 1'b0, 4'd1, 1'b1, 8'h00);
        int_in = 8'h00;
        ticks(3);
        int_in = 8'h01;
        ticks(3);
        check_out("t4.svc_pend", 1'b0, 4'd1, 1'b1, 8'h01);
        ticks(4);
        check_out("t4.no_nest", 1'b0, 4'd1, 1'b1, 8'h01);
        do_reti();
        check_out("t4.reti", 1'b0, 4'd0, 1'b0, 8'h01);
        tick();
        check_out("t4.rereq", 1'b1, 4'd1, 1'b0, 8'h01);

        // Stray reti in REQ, then rise on latched line coincident with ack
        int_in = 8'h00;
        ticks(3);
        do_reti();
        check_out("t5.stray_reti", 1'b1, 4'd1, 1'b0, 8'h01);
        int_in = 8'h01;
        ticks(2);
        do_ack();
        check_out("t5.ack_rise", 1'b0, 4'd1, 1'b1, 8'h01);
        do_reti();
        tick();
        check_out("t5.rereq", 1'b1, 4'd1, 1'b0, 8'h01);
        do_ack();
        check_out("t5.ack2", 1'b0, 4'd1, 1'b1, 8'h00);
        do_reti();
        do_ack();
        check_out("t5.stray_ack", 1'b0, 4'd0, 1'b0, 8'h00);
        int_in = 8'h00;
        ticks(3);

        // Reset while in REQ, line held high through release
        write_mask(8'h80);
        int_in = 8'h08;
        ticks(4);
        check_out("t6.req", 1'b1, 4'd4, 1'b0, 8'h08);
        reset_n = 1'b0;
        #2;
        check_out("t6.rst_req", 1'b0, 4'd0, 1'b0, 8'h00);
        check("t6.rst_req.mask", 32'(mask), 32'h0);
        tick();
        reset_n = 1'b1;
        ticks(8);
        check_out("t6.held_high", 1'b0, 4'd0, 1'b0, 8'h00);

        // Reset while in SERVICE
        int_in = 8'h0C;
        ticks(4);
        check_out("t6.req3", 1'b1, 4'd3, 1'b0, 8'h04);
        do_ack();
        write_mask(8'h80);
        check_out("t6.svc", 1'b0, 4'd3, 1'b1, 8'h00);
        check("t6.svc.mask", 32'(mask), 32'h80);
        reset_n = 1'b0;
        #2;
        check_out("t6.rst_svc", 1'b0, 4'd0, 1'b0, 8'h00);
        check("t6.rst_svc.mask", 32'(mask), 32'h0);
        tick();
        reset_n = 1'b1;
        ticks(8);
        check_out("t6.after", 1'b0, 4'd0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
